// File: rtl/game_flow_fsm.sv
// -----------------------------------------------------------------------------
// game_flow_fsm
//
// Top-level game-flow controller. It sits directly downstream of the lives
// counter and sequences the game through
//   IDLE -> PLAYING -> RESPAWN / GAME_OVER / WIN
// It drives play gating, the respawn blink, the end screens and a restart
// pulse that reloads the lives/score counters.
//
// Optional build feature:
//   PAUSE_KEY_EN  when defined, adds the pause_key input and the PAUSED state
//                 (encoding 5). A rising edge on pause_key toggles between
//                 PLAYING and PAUSED. Without it, encoding 5 is illegal and
//                 recovers to IDLE like 6 and 7.
//
// Parameters:
//   RESPAWN_SECS   oneSecPulse ticks spent in RESPAWN before play resumes (>=1)
//   GAMEOVER_SECS  oneSecPulse ticks the GAME_OVER screen is held (>=1)
//   LIVES_W        width of lives_count / hud_lives
//
// Ports:
//   clk            in   system clock
//   resetN         in   asynchronous active-low reset
//   start_key      in   synchronised start button level (acts on rising edge)
//   oneSecPulse    in   1-cycle pulse once per second
//   hpLoss_trigger in   1-cycle hit event (also feeds the lives counter)
//   life_over      in   high while the lives count is zero
//   lives_count    in   current lives, forwarded to the HUD
//   level_done     in   level-complete flag
//   pause_key      in   synchronised pause button level (PAUSE_KEY_EN only)
//   state          out  current state: IDLE=0 PLAYING=1 RESPAWN=2
//                       GAME_OVER=3 WIN=4 PAUSED=5
//   play_enable    out  high only in PLAYING; gates player/enemy motion
//   blink_on       out  player-sprite blink during RESPAWN
//   respawn_pulse  out  1 cycle, on RESPAWN -> PLAYING
//   restart_pulse  out  1 cycle, on entry to PLAYING from IDLE or WIN
//   game_over      out  high in GAME_OVER
//   win            out  high in WIN
//   hud_lives      out  lives_count delayed by one clock
//
// All outputs are registered. Each output register is loaded from the
// next-state decode, so every output is aligned with the state it belongs to
// and every pulse is high exactly in the cycle after the decision cycle.
// -----------------------------------------------------------------------------
module game_flow_fsm #(
  parameter int RESPAWN_SECS  = 2,
  parameter int GAMEOVER_SECS = 5,
  parameter int LIVES_W       = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               start_key,
  input  logic               oneSecPulse,
  input  logic               hpLoss_trigger,
  input  logic               life_over,
  input  logic [LIVES_W-1:0] lives_count,
  input  logic               level_done,
`ifdef PAUSE_KEY_EN
  input  logic               pause_key,
`endif
  output logic [2:0]         state,
  output logic               play_enable,
  output logic               blink_on,
  output logic               respawn_pulse,
  output logic               restart_pulse,
  output logic               game_over,
  output logic               win,
  output logic [LIVES_W-1:0] hud_lives
);

  // Seconds counter only has to reach the larger of the two hold times.
  localparam int MAX_SECS = (RESPAWN_SECS > GAMEOVER_SECS) ? RESPAWN_SECS
                                                           : GAMEOVER_SECS;
  localparam int CNT_W    = $clog2(MAX_SECS + 1);

  localparam logic [CNT_W-1:0] RESPAWN_LAST  = CNT_W'(RESPAWN_SECS - 1);
  localparam logic [CNT_W-1:0] GAMEOVER_LAST = CNT_W'(GAMEOVER_SECS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAYING   = 3'd1,
    S_RESPAWN   = 3'd2,
    S_GAME_OVER = 3'd3,
`ifdef PAUSE_KEY_EN
    S_PAUSED    = 3'd5,
`endif
    S_WIN       = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_n;
  logic [CNT_W-1:0] sec_cnt;
  logic [CNT_W-1:0] sec_cnt_n;
  logic             blink_n;
  logic             start_d;
  logic             start_rise;

  assign start_rise = start_key & ~start_d;

`ifdef PAUSE_KEY_EN
  logic pause_d;
  logic pause_rise;

  assign pause_rise = pause_key & ~pause_d;
`endif

  assign state = state_q;

  // ---------------------------------------------------------------------------
  // Next-state, seconds-counter and blink decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default before the case; a path
    // that leaves one unassigned would otherwise infer a latch.
    state_n   = state_q;
    sec_cnt_n = sec_cnt;
    blink_n   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_rise) state_n = S_PLAYING;
      end

      // Priority: losing the last life beats a hit, a hit beats finishing the
      // level. A hit coincident with level_done therefore respawns first and
      // the still-asserted level_done is seen again once play resumes.
      S_PLAYING: begin
        if (life_over)           state_n = S_GAME_OVER;
        else if (hpLoss_trigger) state_n = S_RESPAWN;
`ifdef PAUSE_KEY_EN
        else if (pause_rise)     state_n = S_PAUSED;
`endif
        else if (level_done)     state_n = S_WIN;
      end

      // life_over is checked on every RESPAWN cycle: on the final hit the
      // lives counter reaches zero one cycle after the trigger, when this FSM
      // is already in RESPAWN. Further hits are ignored here.
      S_RESPAWN: begin
        if (life_over)
          state_n = S_GAME_OVER;
        else if (oneSecPulse && (sec_cnt == RESPAWN_LAST))
          state_n = S_PLAYING;
      end

      // Start presses are ignored until the screen times out to IDLE.
      S_GAME_OVER: begin
        if (oneSecPulse && (sec_cnt == GAMEOVER_LAST)) state_n = S_IDLE;
      end

      S_WIN: begin
        if (start_rise) state_n = S_PLAYING;
      end

`ifdef PAUSE_KEY_EN
      // Hits and level completion are frozen while paused.
      S_PAUSED: begin
        if (life_over)       state_n = S_GAME_OVER;
        else if (pause_rise) state_n = S_PLAYING;
      end
`endif

      // Unused encodings recover to IDLE on the next clock.
      default: state_n = S_IDLE;
    endcase

    // The counter restarts on every state change, so a pulse landing in a
    // transition cycle is never counted toward the new state's hold time.
    if (state_n != state_q)
      sec_cnt_n = '0;
    else if (oneSecPulse && ((state_q == S_RESPAWN) || (state_q == S_GAME_OVER)))
      sec_cnt_n = sec_cnt + CNT_W'(1);

    // Blink starts dark on entry to RESPAWN, toggles on each second that
    // stays in RESPAWN, and is forced off on any exit.
    if (state_n == S_RESPAWN)
      blink_n = ((state_q == S_RESPAWN) && oneSecPulse) ? ~blink_on : blink_on;
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_IDLE;
      sec_cnt       <= '0;
      start_d       <= 1'b0;
`ifdef PAUSE_KEY_EN
      pause_d       <= 1'b0;
`endif
      play_enable   <= 1'b0;
      blink_on      <= 1'b0;
      respawn_pulse <= 1'b0;
      restart_pulse <= 1'b0;
      game_over     <= 1'b0;
      win           <= 1'b0;
      hud_lives     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values regardless of statement order.
      state_q       <= state_n;
      sec_cnt       <= sec_cnt_n;
      start_d       <= start_key;
`ifdef PAUSE_KEY_EN
      pause_d       <= pause_key;
`endif
      play_enable   <= (state_n == S_PLAYING);
      blink_on      <= blink_n;
      respawn_pulse <= (state_q == S_RESPAWN) && (state_n == S_PLAYING);
      // Un-pausing also enters PLAYING but must not reload the counters.
      restart_pulse <= (state_n == S_PLAYING) &&
                       ((state_q == S_IDLE) || (state_q == S_WIN));
      game_over     <= (state_n == S_GAME_OVER);
      win           <= (state_n == S_WIN);
      hud_lives     <= lives_count;
    end
  end

endmodule
